// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Multi-cycle MIPS main control FSM. Sequences fetch, decode,
//               execute, memory and writeback, driving the datapath enables
//               and the 2-bit ALU_op. Stalls on the mem_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALU_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] c_S_RST    = 4'd0;
    localparam logic [3:0] c_S_FETCH  = 4'd1;
    localparam logic [3:0] c_S_DEC    = 4'd2;
    localparam logic [3:0] c_S_MEMADR = 4'd3;
    localparam logic [3:0] c_S_MEMRD  = 4'd4;
    localparam logic [3:0] c_S_MEMWB  = 4'd5;
    localparam logic [3:0] c_S_MEMWR  = 4'd6;
    localparam logic [3:0] c_S_EXEC   = 4'd7;
    localparam logic [3:0] c_S_ALUWB  = 4'd8;
    localparam logic [3:0] c_S_BRANCH = 4'd9;
    localparam logic [3:0] c_S_JUMP   = 4'd10;
    localparam logic [3:0] c_S_ADDIEX = 4'd11;
    localparam logic [3:0] c_S_ADDIWB = 4'd12;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;

    // With the handshake disabled memory is assumed to complete every cycle.
    assign w_ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign state   = r_state;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        w_next = c_S_FETCH;
        case (r_state)
            c_S_RST:    w_next = c_S_FETCH;
            c_S_FETCH:  w_next = w_ready ? c_S_DEC : c_S_FETCH;
            c_S_DEC: begin
                case (opcode)
                    c_OP_LW, c_OP_SW:   w_next = c_S_MEMADR;
                    c_OP_RTYPE:         w_next = c_S_EXEC;
                    c_OP_BEQ, c_OP_BNE: w_next = c_S_BRANCH;
                    c_OP_ADDI:          w_next = c_S_ADDIEX;
                    c_OP_J:             w_next = c_S_JUMP;
                    default:            w_next = c_S_FETCH;
                endcase
            end
            c_S_MEMADR: w_next = (opcode == c_OP_SW) ? c_S_MEMWR : c_S_MEMRD;
            c_S_MEMRD:  w_next = w_ready ? c_S_MEMWB : c_S_MEMRD;
            c_S_MEMWB:  w_next = c_S_FETCH;
            c_S_MEMWR:  w_next = w_ready ? c_S_FETCH : c_S_MEMWR;
            c_S_EXEC:   w_next = c_S_ALUWB;
            c_S_ALUWB:  w_next = c_S_FETCH;
            c_S_BRANCH: w_next = c_S_FETCH;
            c_S_JUMP:   w_next = c_S_FETCH;
            c_S_ADDIEX: w_next = c_S_ADDIWB;
            c_S_ADDIWB: w_next = c_S_FETCH;
            default:    w_next = c_S_FETCH;
        endcase
    end

    // Datapath controls: everything defaults low, each state raises its own.
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALU_op     = 2'b00;
        illegal_op = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            c_S_DEC: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ,
                    c_OP_BNE, c_OP_ADDI, c_OP_J: illegal_op = 1'b0;
                    default:                     illegal_op = 1'b1;
                endcase
            end
            c_S_MEMADR, c_S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            c_S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            c_S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            c_S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            c_S_EXEC: begin
                ALUSrcA = 1'b1;
                ALU_op  = 2'b10;
            end
            c_S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            c_S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALU_op   = 2'b01;
                PCSrc    = 2'b01;
                Branch   = (opcode == c_OP_BEQ);
                BranchNe = (opcode == c_OP_BNE);
            end
            c_S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            c_S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_control
// Description : Randomized self-checking bench for mc_main_control against an
//               instruction-route reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSrc, ALU_op;
    logic [3:0] state;

    int n_vec;
    int n_err;

    // Reference model: current state plus the route of the instruction in flight.
    int m_state;
    int m_route[$];
    int m_idx;

    mc_main_control #(.USE_MEM_READY(1)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALU_op(ALU_op),
        .illegal_op(illegal_op), .state(state)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [17:0] pack_dut();
        return {PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALU_op, illegal_op};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b000101, 6'b001000, 6'b000010};
    endfunction

    // Expected control word for a state, straight from the state table.
    function automatic logic [17:0] exp_out(input int st, input logic [5:0] op, input logic rdy);
        logic pcw, br, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, pcs, aop;
        {pcw, br, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ill} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  begin asb = 2'b11; ill = !is_legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin iord = 1; mr = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin iord = 1; mw = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin asa = 1; aop = 2'b01; pcs = 2'b01;
                      br = (op == 6'b000100); bne = (op == 6'b000101); end
            10: begin pcs = 2'b10; pcw = 1; end
            11: begin asa = 1; asb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pcw, br, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, aop, ill};
    endfunction

    // State sequence an instruction walks, starting from FETCH.
    task automatic build_route(input logic [5:0] op);
        m_route.delete();
        case (op)
            6'b100011:            m_route = '{1, 2, 3, 4, 5};
            6'b101011:            m_route = '{1, 2, 3, 6};
            6'b000000:            m_route = '{1, 2, 7, 8};
            6'b000100, 6'b000101: m_route = '{1, 2, 9};
            6'b001000:            m_route = '{1, 2, 11, 12};
            6'b000010:            m_route = '{1, 2, 10};
            default:              m_route = '{1, 2};
        endcase
    endtask

    task automatic model_step(input logic rdy);
        if (m_state == 0) begin
            m_state = 1;
        end else if ((m_state == 1 || m_state == 4 || m_state == 6) && !rdy) begin
            m_state = m_state;
        end else if (m_state == 1) begin
            m_idx   = 1;
            m_state = 2;
        end else begin
            if (m_state == 2) build_route(opcode);
            m_idx++;
            m_state = (m_idx < m_route.size()) ? m_route[m_idx] : 1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] pool [7];
        pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b000101, 6'b001000, 6'b000010};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return pool[$urandom_range(0, 6)];
    endfunction

    task automatic check_reset_zero(input string tag);
        chk({tag, "_out"}, 32'(pack_dut()), 32'd0);
        chk({tag, "_st"}, 32'(state), 32'd0);
    endtask

    initial begin
        logic [17:0] w_exp;
        n_vec     = 0;
        n_err     = 0;
        m_idx     = 0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        reset     = 1'b1;
        #1;
        check_reset_zero("reset_init");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        m_state = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_state == 1) opcode = pick_op();
            #1;
            w_exp = exp_out(m_state, opcode, mem_ready);
            chk("state", 32'(state), 32'(m_state));
            chk("ctrl", 32'(pack_dut()), 32'(w_exp));
            chk("no_pcw_branch", 32'(PCWrite & (Branch | BranchNe)), 32'd0);
            chk("no_rd_wr", 32'(MemRead & MemWrite), 32'd0);

            if ($urandom_range(0, 59) == 0) begin
                // Asynchronous abort mid-cycle: controls must drop at once.
                #1 reset = 1'b1;
                #1;
                check_reset_zero("reset_async");
                @(posedge clk);
                #2;
                check_reset_zero("reset_held");
                reset   = 1'b0;
                m_state = 0;
            end else begin
                @(posedge clk);
                model_step(mem_ready);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
